// File: rtl/crc_word_serializer.sv
// CRC5 word serializer: captures a finished CRC5, frames it as {preamble, token, crc}
// and shifts the 11-bit word out MSB first, one bit per bit-tick, then pulses done.
module crc_word_serializer #(
  parameter logic [1:0] PREAMBLE = 2'b01,
  parameter logic [3:0] TOKEN    = 4'b1100
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic [4:0] i_crc_value,
  input  logic       i_crc_valid,
  input  logic       i_bit_tick,
  input  logic       i_abort,
  output logic       o_ready,
  output logic       o_sdo,
  output logic       o_sdo_en,
  output logic       o_done
);

  localparam logic [3:0] LastBit = 4'd10;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [10:0] word_q;
  logic [10:0] load_word;
  logic [3:0]  next_idx;

  always_comb begin
    load_word = {PREAMBLE, TOKEN, i_crc_value};
    // Bit presented after the current one retires; only used while cnt_q < LastBit.
    next_idx  = 4'd9 - cnt_q;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      word_q   <= 11'd0;
      o_ready  <= 1'b1;
      o_sdo    <= 1'b1;
      o_sdo_en <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_crc_valid && !i_abort) begin
            state_q  <= StShift;
            word_q   <= load_word;
            cnt_q    <= 4'd0;
            o_ready  <= 1'b0;
            o_sdo_en <= 1'b1;
            o_sdo    <= load_word[10];
          end
        end
        StShift: begin
          if (i_abort) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            word_q   <= 11'd0;
            o_ready  <= 1'b1;
            o_sdo_en <= 1'b0;
            o_sdo    <= 1'b1;
          end else if (i_bit_tick) begin
            if (cnt_q == LastBit) begin
              state_q  <= StDone;
              o_done   <= 1'b1;
              o_sdo_en <= 1'b0;
              o_sdo    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
              o_sdo <= word_q[next_idx];
            end
          end
        end
        StDone: begin
          // Abort here needs no special handling: the done pulse is already out.
          state_q  <= StIdle;
          cnt_q    <= 4'd0;
          o_ready  <= 1'b1;
          o_sdo_en <= 1'b0;
          o_sdo    <= 1'b1;
        end
        default: begin
          state_q  <= StIdle;
          cnt_q    <= 4'd0;
          o_ready  <= 1'b1;
          o_sdo_en <= 1'b0;
          o_sdo    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_word_serializer.sv
// Bench for crc_word_serializer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_crc_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] val = 5'd0;
  logic       valid = 1'b0;
  logic       tick = 1'b0;
  logic       abort = 1'b0;
  logic       ready, sdo, sdo_en, done;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  crc_word_serializer dut (
    .i_sys_clk  (clk),
    .i_sys_rst  (rst),
    .i_crc_value(val),
    .i_crc_valid(valid),
    .i_bit_tick (tick),
    .i_abort    (abort),
    .o_ready    (ready),
    .o_sdo      (sdo),
    .o_sdo_en   (sdo_en),
    .o_done     (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of bits still to send, plus a one-cycle done flag.
  logic mq[$];
  bit   m_done_f = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [10:0] w;
    logic        unused_bit;
    if (rst) begin
      mq.delete();
      m_done_f = 1'b0;
    end else if (m_done_f) begin
      m_done_f = 1'b0;
    end else if (mq.size() != 0) begin
      if (abort) begin
        mq.delete();
      end else if (tick) begin
        unused_bit = mq.pop_front();
        if (mq.size() == 0) m_done_f = 1'b1;
      end
    end else if (valid && !abort) begin
      w = {2'b01, 4'b1100, val};
      for (int i = 10; i >= 0; i--) mq.push_back(w[i]);
    end
  end

  always @(negedge clk) begin
    logic m_en, m_sdo, m_ready;
    if (chk_en) begin
      m_en    = (mq.size() != 0);
      m_sdo   = m_en ? mq[0] : 1'b1;
      m_ready = !m_en && !m_done_f;
      check("model", 32'({ready, sdo_en, sdo, done}), 32'({m_ready, m_en, m_sdo, m_done_f}));
    end
  end

  task automatic basic_word();
    logic [10:0] got;
    logic [10:0] exp_w;
    exp_w = 11'b01110010110;
    got   = '0;
    @(negedge clk);
    val = 5'b10110; valid = 1'b1; tick = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
      if (k <= 11) begin
        got[11-k] = sdo;
        check("basic_sdo_en", 32'(sdo_en), 1);
      end
      check("basic_done", 32'(done), (k == 12) ? 1 : 0);
      if (k == 13) check("basic_ready", 32'(ready), 1);
    end
    check("basic_bits", 32'(got), 32'(exp_w));
    tick = 1'b0;
  endtask

  task automatic sparse_word();
    logic [10:0] w;
    int n_ticks, tick11, done_at;
    logic last;
    w = {2'b01, 4'b1100, 5'b00001};
    n_ticks = 0; tick11 = -1; done_at = -1; last = 1'b0;
    @(negedge clk);
    val = 5'b00001; valid = 1'b1; tick = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) valid = 1'b0;
      if (done) begin
        done_at = n;
        break;
      end
      if (sdo_en && n_ticks <= 10) begin
        check("sparse_bit", 32'(sdo), 32'(w[10-n_ticks]));
        last = sdo;
      end
      tick = (n % 4 == 0);
      if (tick) begin
        n_ticks++;
        if (n_ticks == 11) tick11 = n;
      end
    end
    tick = 1'b0;
    check("sparse_done_found", 32'(done_at != -1), 1);
    check("sparse_done_latency", 32'(done_at), 32'(tick11 + 1));
    check("sparse_last_bit", 32'(last), 1);
  endtask

  task automatic back_pressure();
    logic [10:0] got;
    logic [10:0] exp_w;
    int ready_at;
    exp_w = {6'b011100, 5'b11111};
    got = '0;
    ready_at = -1;
    @(negedge clk);
    val = 5'b00110; valid = 1'b1; tick = 1'b1;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    val = 5'b11111; valid = 1'b1;
    for (int c = 4; c <= 40; c++) begin
      @(negedge clk);
      if (ready) begin
        ready_at = c;
        break;
      end
    end
    check("bp_ready_cycle", 32'(ready_at), 13);
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      got[10-i] = sdo;
      check("bp_sdo_en", 32'(sdo_en), 1);
      @(negedge clk);
    end
    check("bp_second_word", 32'(got), 32'(exp_w));
    check("bp_done", 32'(done), 1);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic abort_word();
    @(negedge clk);
    val = 5'($urandom); valid = 1'b1; tick = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", 32'({ready, sdo_en, sdo, done}), 32'(4'b1010));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 0);
    end
    abort = 1'b1; valid = 1'b1; val = 5'b10101;
    @(negedge clk);
    abort = 1'b0; valid = 1'b0;
    check("abort_valid_idle", 32'({ready, sdo_en}), 32'(2'b10));
    tick = 1'b0;
  endtask

  task automatic reset_mid_word();
    @(negedge clk);
    val = 5'b01010; valid = 1'b1; tick = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1 check("async_reset", 32'({ready, sdo_en, sdo, done}), 32'(4'b1010));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; val = 5'b00000; valid = 1'b1; tick = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("post_reset_bit10", 32'({sdo_en, sdo}), 32'(2'b10));
    @(negedge clk);
    check("post_reset_bit9", 32'({sdo_en, sdo}), 32'(2'b11));
    for (int i = 0; i < 14; i++) @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check("reset_vals", 32'({ready, sdo_en, sdo, done}), 32'(4'b1010));
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    basic_word();
    sparse_word();
    back_pressure();
    abort_word();
    reset_mid_word();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      valid = ($urandom % 3 == 0);
      val   = 5'($urandom);
      tick  = ($urandom % 2 == 0);
      abort = ($urandom % 25 == 0);
    end
    @(negedge clk);
    valid = 1'b0; tick = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_word_serializer.md
# crc_word_serializer

Downstream stage of the HDR-DDR CRC5 generator. Captures the finished 5-bit CRC when the generator flags it valid and builds the 11-bit CRC word: 2-bit preamble, 4-bit token, CRC5 MSB first. It shifts the word out one bit per bit-tick toward the SDA driver, then pulses done. One word is in flight at a time; a ready/valid handshake back-pressures the CRC stage.

## Interface
- PREAMBLE, 2'b01, preamble bits, sent MSB first
- TOKEN, 4'b1100, CRC token, sent MSB first
- i_sys_clk  in  1  system clock; all logic on its rising edge
- i_sys_rst  in  1  asynchronous, active-high reset
- i_crc_value  in  5  CRC5 from the CRC stage
- i_crc_valid  in  1  i_crc_value is valid; captured when o_ready=1
- i_bit_tick  in  1  one-cycle strobe: advance to the next bit
- i_abort  in  1  drop the current word and return to IDLE
- o_ready  out  1  serializer can accept a CRC
- o_sdo  out  1  current serial bit
- o_sdo_en  out  1  o_sdo is driven (tri-state enable for the SDA mux)
- o_done  out  1  one-cycle pulse: word fully sent

## Operation
- Word register is 11 bits: {PREAMBLE, TOKEN, i_crc_value}. Bit 10 is sent first.
- 4-bit bit counter counts 0..10. State machine:
  - IDLE: o_ready=1, o_sdo_en=0, o_sdo=1.
    - i_crc_valid=1 and i_abort=0 -> load the word register, counter=0, go to SHIFT.
    - Otherwise stay in IDLE.
    - i_bit_tick is ignored in IDLE.
  - SHIFT: o_ready=0, o_sdo_en=1, o_sdo = word bit (10 - counter).
    - i_bit_tick with counter<10 -> counter+1.
    - i_bit_tick with counter=10 -> go to DONE.
    - No tick -> hold the bit.
  - DONE: o_done=1, o_sdo_en=0, o_sdo=1, o_ready=0. Go to IDLE unconditionally after 1 cycle.
- i_abort in SHIFT or DONE: go to IDLE next cycle. o_done is not asserted and the word is discarded. Abort in DONE suppresses nothing, because the pulse is already in progress that cycle.
- i_abort and i_crc_valid together in IDLE: abort wins and nothing is captured.
- i_crc_valid while o_ready=0: ignored. The CRC stage must hold valid until it sees ready.
- Abort and tick in the same cycle: abort wins.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset (async, immediate) values: state=IDLE, counter=0, word=0, o_ready=1, o_sdo=1, o_sdo_en=0, o_done=0.
- Reset mid-word: outputs return to their reset values at once. No o_done is produced.
- With the capture edge at cycle 0, cycle 1 presents bit 10 (PREAMBLE[1]).
- Each bit is presented from the cycle after the tick that retired the previous bit.
- With i_bit_tick held high continuously:
  - bits appear on cycles 1..11;
  - o_done=1 on cycle 12;
  - o_ready=1 on cycle 13.
- Minimum spacing between accepted words is 13 cycles.
- With sparse ticks, each bit is held until its retiring tick. Latency = 1 + (cycles to the 11th tick) + 1.

## Test plan
- Basic word, continuous ticks:
  - Stimulus: i_crc_value=5'b10110, i_crc_valid for 1 cycle, i_bit_tick=1.
  - Required: o_sdo on cycles 1..11 = 0,1,1,1,0,0,1,0,1,1,0 with o_sdo_en=1; o_done=1 on cycle 12 only; o_ready=1 on cycle 13.
- Sparse ticks:
  - Stimulus: i_crc_value=5'b00001, i_bit_tick every 4th cycle.
  - Required: each bit is held stable until its tick; final bit is 1; o_done is 1 cycle after the 11th tick.
- Back-pressure:
  - Stimulus: second i_crc_valid with value 5'b11111 during SHIFT, then held high.
  - Required: ignored while busy; captured on the first cycle o_ready=1; second word ends in 1,1,1,1,1.
- Abort:
  - Stimulus: i_abort during bit 6.
  - Required: next cycle IDLE, o_sdo_en=0, o_ready=1, no o_done.
  - Abort together with i_crc_valid in IDLE: no capture, o_sdo_en stays 0.
- Async reset:
  - Stimulus: assert i_sys_rst between clock edges during bit 3.
  - Required: o_sdo_en=0, o_sdo=1, o_ready=1 immediately, with no clock edge needed.
  - After release, a new word serializes from the preamble.
- Default parameters:
  - Required: the first 6 bits of every word are 0,1,1,1,0,0.
